// File: rtl/pipe_cla_adder_if.sv
// Valid/ready operand and result bus for pipe_cla_adder.
// Carries the extra ovf result bit only when PIPE_CLA_OVF_EN is defined.
interface pipe_cla_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_CLA_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES slice per stage.
// Define PIPE_CLA_OVF_EN to add the pipelined signed-overflow output ovf.
module pipe_cla_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_cla_adder_if.slave bus
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / GROUP;

    if ((WIDTH % (GROUP * STAGES)) != 0 || (GROUP != 4 && GROUP != 8) ||
        STAGES == 0 || STAGES > (WIDTH / GROUP)) begin : g_bad_cfg
        $error("pipe_cla_adder: illegal WIDTH/GROUP/STAGES combination");
    end

    // One slice: group generate/propagate decide each group's carry-out.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        logic          gg;
        logic          gp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int unsigned j = 0; j < NG; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int unsigned i = 0; i < GROUP; i++) begin
                c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
                gg             = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
                gp             = gp & p[j*GROUP+i];
            end
            c[(j+1)*GROUP] = gg | (gp & c[j*GROUP]);
        end
        return {c[SW], p ^ c[SW-1:0]};
    endfunction

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q,   c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] adv_c;
    logic              in_ready_c;
`ifdef PIPE_CLA_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // Backward ready chain: a stage advances if everything below it can take its data.
    always_comb begin : p_flow
        logic free;
        free  = bus.out_ready;
        adv_c = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            adv_c[k] = vld_q[k] & free;
            free     = ~vld_q[k] | free;
        end
        in_ready_c = free;
    end

    // Stage k adds slice k of the operands it receives and forwards the rest.
    always_comb begin : p_data
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        logic [WIDTH-1:0] ss;
        logic             sc;
        logic             load;
        logic [SW:0]      r;
        sa    = '0;
        sb    = '0;
        ss    = '0;
        sc    = 1'b0;
        load  = 1'b0;
        r     = '0;
        vld_d = vld_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
`ifdef PIPE_CLA_OVF_EN
        ovf_d = ovf_q;
`endif
        for (int k = 0; k < int'(STAGES); k++) begin
            if (k == 0) begin
                sa   = bus.a;
                sb   = bus.b ^ {WIDTH{bus.sub}};
                ss   = '0;
                sc   = bus.cin ^ bus.sub;
                load = bus.in_valid & in_ready_c;
            end else begin
                sa   = a_q[k-1];
                sb   = b_q[k-1];
                ss   = s_q[k-1];
                sc   = c_q[k-1];
                load = adv_c[k-1];
            end
            r               = cla_slice(sa[k*SW +: SW], sb[k*SW +: SW], sc);
            ss[k*SW +: SW]  = r[SW-1:0];
            vld_d[k]        = load | (vld_q[k] & ~adv_c[k]);
            if (load) begin
                a_d[k] = sa;
                b_d[k] = sb;
                s_d[k] = ss;
                c_d[k] = r[SW];
`ifdef PIPE_CLA_OVF_EN
                if (k == int'(STAGES) - 1) begin
                    ovf_d = (sa[WIDTH-1] == sb[WIDTH-1]) & (ss[WIDTH-1] != sa[WIDTH-1]);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
`ifdef PIPE_CLA_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
`ifdef PIPE_CLA_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
`ifdef PIPE_CLA_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
